// File: rtl/regfile_scoreboard.sv
// Architectural register file with two bypassed read ports, a per-register
// pending-write scoreboard and the decode-stage RAW/saturation stall.
module regfile_scoreboard #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int PEND_W    = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [4:0]           rs_addr,
    input  logic [4:0]           rt_addr,
    input  logic                 rs_used,
    input  logic                 rt_used,
    output logic [DATA_SIZE-1:0] rs_data,
    output logic [DATA_SIZE-1:0] rt_data,
    input  logic                 issue_valid,
    input  logic                 issue_writes,
    input  logic [4:0]           issue_dest,
    input  logic [4:0]           WB_dest,
    input  logic [DATA_SIZE-1:0] WB_value,
    input  logic                 WB_WEenable,
    output logic                 stall,
    output logic                 sb_err
);

    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_TWO  = PEND_W'(2);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    logic [DATA_SIZE-1:0] regs [NUM_REGS];
    logic [PEND_W-1:0]    pend [NUM_REGS];

    logic                retire;
    logic                issue_fire;
    logic                underflow;
    logic                rs_wb_hit;
    logic                rt_wb_hit;
    logic                rs_hazard;
    logic                rt_hazard;
    logic                sat_hazard;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    assign retire    = WB_WEenable && (WB_dest != 5'd0);
    assign rs_wb_hit = WB_WEenable && (WB_dest == rs_addr);
    assign rt_wb_hit = WB_WEenable && (WB_dest == rt_addr);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == 5'd0)
            rs_data = '0;
        else if (rs_wb_hit)
            rs_data = WB_value;

        rt_data = regs[rt_addr];
        if (rt_addr == 5'd0)
            rt_data = '0;
        else if (rt_wb_hit)
            rt_data = WB_value;
    end

    // A single outstanding write that completes this cycle is satisfied by the bypass.
    assign rs_hazard = rs_used && (rs_addr != 5'd0) &&
                       ((pend[rs_addr] >= PEND_TWO) ||
                        ((pend[rs_addr] == PEND_ONE) && !rs_wb_hit));
    assign rt_hazard = rt_used && (rt_addr != 5'd0) &&
                       ((pend[rt_addr] >= PEND_TWO) ||
                        ((pend[rt_addr] == PEND_ONE) && !rt_wb_hit));
    assign sat_hazard = issue_valid && issue_writes && (issue_dest != 5'd0) &&
                        (pend[issue_dest] == PEND_MAX) &&
                        !(retire && (WB_dest == issue_dest));

    assign stall      = reset_n && issue_valid && (rs_hazard || rt_hazard || sat_hazard);
    assign issue_fire = issue_valid && issue_writes && !stall && (issue_dest != 5'd0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_fire)
            inc_vec[issue_dest] = 1'b1;
        if (retire)
            dec_vec[WB_dest] = 1'b1;
    end

    assign underflow = retire && !inc_vec[WB_dest] && (pend[WB_dest] == PEND_ZERO);

    // NOTE: state uses non-blocking assignments; the register array is reset
    // because software-visible registers must read zero after reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (retire)
                regs[WB_dest] <= WB_value;
            for (int r = 0; r < NUM_REGS; r++) begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10:   pend[r] <= pend[r] + PEND_ONE;
                    2'b01:   if (pend[r] != PEND_ZERO) pend[r] <= pend[r] - PEND_ONE;
                    default: ;
                endcase
            end
            if (underflow)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a behavioural model of register contents and outstanding-write counts.
module tb_regfile_scoreboard;

    localparam int PEND_CAP = 7;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  rs_addr, rt_addr, issue_dest, WB_dest;
    logic        rs_used, rt_used, issue_valid, issue_writes, WB_WEenable;
    logic [31:0] WB_value;
    logic [31:0] rs_data, rt_data;
    logic        stall, sb_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    int          m_pend [32];
    bit          m_err;

    regfile_scoreboard dut (
        .clock(clock), .reset_n(reset_n),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
        .rs_data(rs_data), .rt_data(rt_data),
        .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
        .WB_dest(WB_dest), .WB_value(WB_value), .WB_WEenable(WB_WEenable),
        .stall(stall), .sb_err(sb_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (WB_WEenable && WB_dest == a) return WB_value;
        return m_regs[a];
    endfunction

    // Hazard = writes to the source still outstanding after this cycle's writeback.
    function automatic bit m_src_hazard(input logic used, input logic [4:0] a);
        int left;
        if (!used || a == 0) return 1'b0;
        left = m_pend[a] - ((WB_WEenable && WB_dest == a) ? 1 : 0);
        return left > 0;
    endfunction

    function automatic bit m_stall();
        bit sat;
        if (!reset_n || !issue_valid) return 1'b0;
        sat = issue_writes && issue_dest != 0 && m_pend[issue_dest] >= PEND_CAP &&
              !(WB_WEenable && WB_dest == issue_dest);
        return m_src_hazard(rs_used, rs_addr) || m_src_hazard(rt_used, rt_addr) || sat;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_pend[r] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic m_update();
        bit issue, retire;
        if (!reset_n) begin
            m_reset();
            return;
        end
        issue  = issue_valid && issue_writes && issue_dest != 0 && !m_stall();
        retire = WB_WEenable && WB_dest != 0;
        if (retire) m_regs[WB_dest] = WB_value;
        if (issue) m_pend[issue_dest]++;
        if (retire) begin
            if (m_pend[WB_dest] == 0) m_err = 1'b1;
            else m_pend[WB_dest]--;
        end
    endtask

    task automatic eval();
        @(negedge clock);
        check("rs_data", rs_data, m_read(rs_addr));
        check("rt_data", rt_data, m_read(rt_addr));
        check("stall", 32'(stall), 32'(m_stall()));
        check("sb_err", 32'(sb_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clock);
        m_update();
        #1;
    endtask

    task automatic idle();
        rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
        issue_valid = 0; issue_writes = 0; issue_dest = 0;
        WB_WEenable = 0; WB_dest = 0; WB_value = 0;
    endtask

    task automatic do_issue(input logic [4:0] d);
        idle();
        issue_valid = 1; issue_writes = 1; issue_dest = d;
        eval(); tick();
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 15) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        int cands[$];
        idle();
        reset_n = 0;
        repeat (2) @(posedge clock);
        m_reset();
        #1;
        reset_n = 1;

        // Post-reset reads
        rs_addr = 5; rt_addr = 0;
        eval();
        check("reset_rs", rs_data, 32'd0);
        check("reset_rt", rt_data, 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_err", 32'(sb_err), 32'd0);
        tick();

        // Bypass then storage read, and register 0 write ignored
        do_issue(7);
        idle();
        WB_WEenable = 1; WB_dest = 7; WB_value = 32'hDEADBEEF; rs_addr = 7;
        eval();
        check("bypass_r7", rs_data, 32'hDEADBEEF);
        tick();
        idle(); rs_addr = 7;
        eval();
        check("stored_r7", rs_data, 32'hDEADBEEF);
        tick();
        idle(); WB_WEenable = 1; WB_dest = 0; WB_value = 32'h1234; rs_addr = 0;
        eval(); tick();
        idle(); rs_addr = 0; rt_addr = 7;
        eval();
        check("r0_zero", rs_data, 32'd0);
        tick();

        // Single RAW hazard resolved by writeback bypass
        do_issue(3);
        idle(); issue_valid = 1; rs_addr = 3; rs_used = 1;
        eval();
        check("raw_r3_stall", 32'(stall), 32'd1);
        tick();
        WB_WEenable = 1; WB_dest = 3; WB_value = 42;
        eval();
        check("raw_r3_release", 32'(stall), 32'd0);
        check("raw_r3_data", rs_data, 32'd42);
        tick();

        // Two outstanding writes to r4
        do_issue(4);
        do_issue(4);
        idle(); issue_valid = 1; rt_addr = 4; rt_used = 1;
        WB_WEenable = 1; WB_dest = 4; WB_value = 32'h44;
        eval();
        check("r4_first_wb_stall", 32'(stall), 32'd1);
        tick();
        WB_value = 32'h45;
        eval();
        check("r4_second_wb_stall", 32'(stall), 32'd0);
        tick();
        WB_WEenable = 0;
        eval();
        check("r4_drained_stall", 32'(stall), 32'd0);
        check("r4_drained_data", rt_data, 32'h45);
        tick();

        // Simultaneous issue and retire on r9 leaves one outstanding
        do_issue(9);
        idle(); issue_valid = 1; issue_writes = 1; issue_dest = 9;
        WB_WEenable = 1; WB_dest = 9; WB_value = 32'h99;
        eval(); tick();
        idle(); issue_valid = 1; rs_addr = 9; rs_used = 1;
        eval();
        check("r9_still_pending", 32'(stall), 32'd1);
        tick();

        // Saturation of r5
        for (int i = 0; i < PEND_CAP; i++) do_issue(5);
        idle(); issue_valid = 1; issue_writes = 1; issue_dest = 5;
        eval();
        check("sat_stall", 32'(stall), 32'd1);
        tick();
        WB_WEenable = 1; WB_dest = 5; WB_value = 32'h55;
        eval();
        check("sat_with_retire", 32'(stall), 32'd0);
        tick();

        // Underflow sets sticky error; reset clears everything
        idle(); WB_WEenable = 1; WB_dest = 12; WB_value = 32'hC;
        eval(); tick();
        idle();
        eval();
        check("err_set", 32'(sb_err), 32'd1);
        tick();
        eval();
        check("err_sticky", 32'(sb_err), 32'd1);
        tick();
        reset_n = 0; issue_valid = 1; rs_addr = 9; rs_used = 1;
        eval();
        check("stall_in_reset", 32'(stall), 32'd0);
        tick();
        reset_n = 1; rs_addr = 9; rt_addr = 7;
        eval();
        check("post_reset_err", 32'(sb_err), 32'd0);
        check("post_reset_r9_stall", 32'(stall), 32'd0);
        check("post_reset_r7", rt_data, 32'd0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset_n      = ($urandom_range(0, 249) != 0);
            issue_valid  = ($urandom_range(0, 9) < 7);
            issue_writes = ($urandom_range(0, 3) != 0);
            issue_dest   = pick();
            rs_addr      = pick();
            rt_addr      = pick();
            rs_used      = 1'($urandom_range(0, 1));
            rt_used      = 1'($urandom_range(0, 1));
            WB_WEenable  = ($urandom_range(0, 9) < 4);
            WB_value     = $urandom;
            cands.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r] > 0) cands.push_back(r);
            if (cands.size() > 0 && $urandom_range(0, 9) != 0)
                WB_dest = 5'(cands[$urandom_range(0, cands.size() - 1)]);
            else
                WB_dest = pick();
            eval();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
